// File: rtl/julia_iter.sv
// Julia-set iteration engine: iterates z <- z^2 + c in signed Q16.16, one step per clock,
// until |z|^2 > 4.0 or MAX_ITER, then reports the count and escape flag over valid/ready.
module julia_iter #(
   parameter int MAX_ITER = 255,
   parameter int IW       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [31:0]   z0_re,
   input  logic signed [31:0]   z0_im,
   input  logic signed [31:0]   c_re,
   input  logic signed [31:0]   c_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IW-1:0]        iter_count,
   output logic                 escaped
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic signed [32:0] ESC_LIM = 33'sh0_0004_0000;
   localparam logic [IW-1:0]      N_MAX   = IW'(MAX_ITER);

   // Q16.16 product: full 64-bit signed product, keep bits [47:16] (floor toward -inf).
   function automatic logic signed [31:0] q_mul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
      logic signed [63:0] p;
      p = 64'(a) * 64'(b);
      return 32'(p >>> 16);
   endfunction

   logic [1:0]           r_state;
   logic signed [31:0]   r_x;
   logic signed [31:0]   r_y;
   logic signed [31:0]   r_cre;
   logic signed [31:0]   r_cim;
   logic [IW-1:0]        r_n;
   logic [IW-1:0]        r_count;
   logic                 r_esc;
   logic                 r_ovld;

   logic signed [31:0]   w_x2;
   logic signed [31:0]   w_y2;
   logic signed [31:0]   w_xy;
   logic signed [32:0]   w_mag;
   logic signed [31:0]   w_xn;
   logic signed [31:0]   w_yn;
   logic                 w_escape;
   logic                 w_last;

   assign w_x2 = q_mul(r_x, r_x);
   assign w_y2 = q_mul(r_y, r_y);
   assign w_xy = q_mul(r_x, r_y);

   // Magnitude is summed one bit wider so it cannot wrap before the escape compare.
   assign w_mag    = $signed({w_x2[31], w_x2}) + $signed({w_y2[31], w_y2});
   assign w_escape = (w_mag > ESC_LIM);
   assign w_last   = (r_n == N_MAX);

   assign w_xn = w_x2 - w_y2 + r_cre;
   assign w_yn = (w_xy <<< 1) + r_cim;

   assign in_ready   = (r_state == S_IDLE) && !rst;
   assign out_valid  = r_ovld;
   assign iter_count = r_count;
   assign escaped    = r_esc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_cre   <= '0;
         r_cim   <= '0;
         r_n     <= '0;
         r_count <= '0;
         r_esc   <= 1'b0;
         r_ovld  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x     <= z0_re;
                  r_y     <= z0_im;
                  r_cre   <= c_re;
                  r_cim   <= c_im;
                  r_n     <= '0;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               if (w_escape) begin
                  r_count <= r_n;
                  r_esc   <= 1'b1;
                  r_ovld  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_last) begin
                  r_count <= N_MAX;
                  r_esc   <= 1'b0;
                  r_ovld  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_x <= w_xn;
                  r_y <= w_yn;
                  r_n <= r_n + IW'(1);
               end
            end
            S_DONE: begin
               // Result stays put until the colour mapper takes it; new jobs wait for IDLE.
               if (out_ready) begin
                  r_ovld  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
